// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared 6502 core types: flag commands and status bit indices
package cpu_pkg;

    typedef enum logic [3:0] {
        FLG_NOP  = 4'd0,
        FLG_NZ   = 4'd1,
        FLG_NZC  = 4'd2,
        FLG_NZCV = 4'd3,
        FLG_NZS  = 4'd4,
        FLG_BIT  = 4'd5,
        FLG_PLP  = 4'd6,
        FLG_CLC  = 4'd7,
        FLG_SEC  = 4'd8,
        FLG_CLI  = 4'd9,
        FLG_SEI  = 4'd10,
        FLG_CLV  = 4'd11,
        FLG_CLD  = 4'd12,
        FLG_SED  = 4'd13,
        FLG_INT  = 4'd14
    } flag_op_t;

    localparam int FLAG_N = 7;
    localparam int FLAG_V = 6;
    localparam int FLAG_U = 5;
    localparam int FLAG_B = 4;
    localparam int FLAG_D = 3;
    localparam int FLAG_I = 2;
    localparam int FLAG_Z = 1;
    localparam int FLAG_C = 0;

    // U and B are not real storage; they only exist in pushed copies of P
    localparam logic [7:0] UB_MASK = 8'h30;

endpackage

// File: rtl/status_flags.sv
// rtl/status_flags.sv - 6502 processor status register with one-stage flag command pipeline
module status_flags
    import cpu_pkg::*;
#(
    parameter logic [7:0] RESET_P = 8'h04
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] flag_op,
    input  logic [7:0] bus_in,
    input  logic [7:0] alu_out,
    input  logic       alu_c,
    input  logic       alu_v,
    input  logic       shift_c,
    output logic [7:0] p,
    output logic [7:0] p_irq,
    output logic       c_fwd,
    output logic       pend
);

    logic [3:0] op_r;
    logic [7:0] bus_r;
    logic [7:0] p_r;
    logic [7:0] p_next;
    logic       zr;
    logic       nr;

    always_ff @(posedge clk) begin
        if (rst) begin
            op_r  <= FLG_NOP;
            bus_r <= 8'h00;
            p_r   <= RESET_P & ~UB_MASK;
        end else begin
            op_r  <= flag_op;
            bus_r <= bus_in;
            p_r   <= p_next;
        end
    end

    // Stage 2: op_r meets the ALU result that was registered alongside it
    always_comb begin
        p_next = p_r;
        zr     = (alu_out == 8'h00);
        nr     = alu_out[7];
        case (op_r)
            FLG_NZ: begin
                p_next[FLAG_N] = nr;
                p_next[FLAG_Z] = zr;
            end
            FLG_NZC: begin
                p_next[FLAG_N] = nr;
                p_next[FLAG_Z] = zr;
                p_next[FLAG_C] = alu_c;
            end
            FLG_NZCV: begin
                p_next[FLAG_N] = nr;
                p_next[FLAG_Z] = zr;
                p_next[FLAG_C] = alu_c;
                p_next[FLAG_V] = alu_v;
            end
            FLG_NZS: begin
                p_next[FLAG_N] = nr;
                p_next[FLAG_Z] = zr;
                p_next[FLAG_C] = shift_c;
            end
            FLG_BIT: begin
                p_next[FLAG_N] = bus_r[7];
                p_next[FLAG_V] = bus_r[6];
                p_next[FLAG_Z] = zr;
            end
            FLG_PLP: p_next = bus_r & ~UB_MASK;
            FLG_CLC: p_next[FLAG_C] = 1'b0;
            FLG_SEC: p_next[FLAG_C] = 1'b1;
            FLG_CLI: p_next[FLAG_I] = 1'b0;
            FLG_SEI: p_next[FLAG_I] = 1'b1;
            FLG_CLV: p_next[FLAG_V] = 1'b0;
            FLG_CLD: p_next[FLAG_D] = 1'b0;
            FLG_SED: p_next[FLAG_D] = 1'b1;
            FLG_INT: p_next[FLAG_I] = 1'b1;
            default: ;
        endcase
    end

    // Commands that leave C alone pass P.C through, so this is always the post-commit carry
    assign c_fwd = p_next[FLAG_C];
    assign pend  = (op_r != FLG_NOP);
    assign p     = p_r | UB_MASK;
    assign p_irq = p_r | (UB_MASK & ~(8'h01 << FLAG_B));

endmodule

// File: tb/tb_status_flags.sv
// tb/tb_status_flags.sv - directed and randomized check of status_flags against a flag-rule model
module tb_status_flags;
    import cpu_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] flag_op;
    logic [7:0] bus_in;
    logic [7:0] alu_out;
    logic       alu_c;
    logic       alu_v;
    logic       shift_c;
    logic [7:0] p;
    logic [7:0] p_irq;
    logic       c_fwd;
    logic       pend;

    int vectors = 0;
    int miscompares = 0;

    // Model state: architectural P (only N,V,D,I,Z,C meaningful) and the command awaiting commit
    logic [7:0] m_p;
    logic [3:0] m_op;
    logic [7:0] m_bus;
    logic       cf_seen;

    status_flags #(.RESET_P(8'h04)) dut (
        .clk(clk), .rst(rst), .flag_op(flag_op), .bus_in(bus_in),
        .alu_out(alu_out), .alu_c(alu_c), .alu_v(alu_v), .shift_c(shift_c),
        .p(p), .p_irq(p_irq), .c_fwd(c_fwd), .pend(pend)
    );

    always #5 clk = ~clk;

    // Flag rules expressed as "which flags change and to what", one row per command family
    function automatic logic [7:0] commit(input logic [7:0] cur, input logic [3:0] op,
                                          input logic [7:0] bus, input logic [7:0] res,
                                          input logic c, input logic v, input logic s);
        logic n, vv, d, i, z, cc;
        {n, vv, d, i, z, cc} = {cur[7], cur[6], cur[3], cur[2], cur[1], cur[0]};
        if (op inside {FLG_NZ, FLG_NZC, FLG_NZCV, FLG_NZS}) begin
            n = res[7];
            z = (res == 0);
        end
        if (op == FLG_NZC || op == FLG_NZCV) cc = c;
        if (op == FLG_NZCV) vv = v;
        if (op == FLG_NZS) cc = s;
        if (op == FLG_BIT) begin
            n = bus[7]; vv = bus[6]; z = (res == 0);
        end
        if (op == FLG_PLP) {n, vv, d, i, z, cc} = {bus[7], bus[6], bus[3], bus[2], bus[1], bus[0]};
        if (op == FLG_CLC) cc = 0;
        if (op == FLG_SEC) cc = 1;
        if (op == FLG_CLI) i = 0;
        if (op == FLG_SEI || op == FLG_INT) i = 1;
        if (op == FLG_CLV) vv = 0;
        if (op == FLG_CLD) d = 0;
        if (op == FLG_SED) d = 1;
        return {n, vv, 2'b00, d, i, z, cc};
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: drive new command plus ALU result for the pending one, check before and after the edge
    task automatic cyc(input logic [3:0] op, input logic [7:0] bus, input logic [7:0] res,
                       input logic c, input logic v, input logic s, input logic r);
        logic [7:0] nxt;
        @(negedge clk);
        flag_op = op; bus_in = bus; alu_out = res;
        alu_c = c; alu_v = v; shift_c = s; rst = r;
        #1;
        nxt = commit(m_p, m_op, m_bus, res, c, v, s);
        cf_seen = c_fwd;
        chk("c_fwd", {7'd0, c_fwd}, {7'd0, nxt[0]});
        @(posedge clk);
        if (r) begin
            m_p = 8'h04; m_op = FLG_NOP; m_bus = 8'h00;
        end else begin
            m_p = nxt; m_op = op; m_bus = bus;
        end
        #1;
        chk("p", p, m_p | 8'h30);
        chk("p_irq", p_irq, m_p | 8'h20);
        chk("pend", {7'd0, pend}, {7'd0, m_op != 4'd0});
    endtask

    task automatic op1(input logic [3:0] op, input logic [7:0] bus);
        cyc(op, bus, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic res1(input logic [3:0] op, input logic [7:0] res, input logic c,
                        input logic v, input logic s);
        cyc(op, 8'h00, res, c, v, s, 1'b0);
    endtask

    initial begin
        rst = 1'b1; flag_op = 4'd0; bus_in = 8'h00; alu_out = 8'h00;
        alu_c = 1'b0; alu_v = 1'b0; shift_c = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        m_p = 8'h04; m_op = FLG_NOP; m_bus = 8'h00;
        chk("reset_p", p, 8'h34);
        chk("reset_p_irq", p_irq, 8'h24);
        chk("reset_c_fwd", {7'd0, c_fwd}, 8'h00);
        chk("reset_pend", {7'd0, pend}, 8'h00);

        // ADC 0x50+0x50
        cyc(FLG_NZCV, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        op1(FLG_NZCV, 8'h00);
        res1(FLG_NOP, 8'hA0, 1'b0, 1'b1, 1'b0);
        chk("adc_p", p, 8'hF4);

        // CLV then CMP equal
        op1(FLG_CLV, 8'h00);
        op1(FLG_NZC, 8'h00);
        res1(FLG_NOP, 8'h00, 1'b1, 1'b0, 1'b0);
        chk("cmp_p", p, 8'h37);

        // SEC then ADC back-to-back: carry must be forwarded
        op1(FLG_CLC, 8'h00);
        op1(FLG_SEC, 8'h00);
        op1(FLG_NZCV, 8'h00);
        chk("sec_adc_cfwd", {7'd0, cf_seen}, 8'h01);
        res1(FLG_NZ, 8'h01, 1'b1, 1'b0, 1'b0);
        res1(FLG_NOP, 8'h00, 1'b0, 1'b1, 1'b0);
        chk("nz_zero_p", p, 8'h37);

        // BIT with C0 and zero AND result
        op1(FLG_BIT, 8'hC0);
        res1(FLG_NOP, 8'h00, 1'b0, 1'b0, 1'b0);
        chk("bit_p", p, 8'hF7);

        // PLP all ones then all zeros
        op1(FLG_PLP, 8'hFF);
        op1(FLG_PLP, 8'h00);
        chk("plp_ff_p", p, 8'hFF);
        op1(FLG_NOP, 8'h00);
        chk("plp_00_p", p, 8'h30);
        chk("plp_00_p_irq", p_irq, 8'h20);

        // Shift out a 1 with negative result, then interrupt entry
        op1(FLG_NZS, 8'h00);
        res1(FLG_INT, 8'h80, 1'b0, 1'b0, 1'b1);
        chk("shift_p", p, 8'hB1);
        op1(FLG_NOP, 8'h00);
        chk("int_p", p, 8'hB5);

        // CLI then SEI: I drops for exactly one cycle
        op1(FLG_CLI, 8'h00);
        op1(FLG_SEI, 8'h00);
        chk("cli_p", p, 8'hB1);
        op1(FLG_NOP, 8'h00);
        chk("sei_p", p, 8'hB5);

        // Reset lands while SEC is in flight
        op1(FLG_CLC, 8'h00);
        op1(FLG_SEC, 8'h00);
        cyc(FLG_NOP, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("rst_flight_p", p, 8'h34);
        chk("rst_flight_pend", {7'd0, pend}, 8'h00);
        op1(FLG_NOP, 8'h00);
        chk("rst_flight_after_p", p, 8'h34);

        // Randomized traffic, including all 16 encodings and occasional reset
        for (int k = 0; k < 400; k++) begin
            cyc(4'($urandom_range(0, 15)), 8'($urandom), 8'($urandom_range(0, 3) == 0 ? 0 : $urandom),
                1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom_range(0, 49) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/status_flags.md
Name: status_flags

Overview:
- Processor status register (P) for the 6502 core; sits directly downstream of the ALU and consumes its registered result (out, sumC, sumV).
- The decoder issues a flag command in the same cycle it issues the ALU op. The command is pipelined one stage so it lines up with the ALU's registered-input result, then commits to P.
- Also owns SEx/CLx, PLP/RTI loads, BIT, and interrupt I-set. Provides a forwarded carry back to the ALU ci input.

Parameters:
- RESET_P, 8'h04: reset value of N,V,D,I,Z,C bits (bits 7,6,3,2,1,0). Bits 5 and 4 are ignored.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- flag_op  in  4  flag command (flag_op_t), issued same cycle as the ALU op
- bus_in  in  8  data byte for FLG_PLP/FLG_BIT, sampled with flag_op
- alu_out  in  8  ALU out, valid the cycle after issue
- alu_c  in  1  ALU sumC, aligned with alu_out
- alu_v  in  1  ALU sumV, aligned with alu_out
- shift_c  in  1  bit shifted out by ASL/LSR/ROL/ROR, aligned with alu_out
- p  out  8  status for PHP/BRK push: bit5=1, bit4(B)=1
- p_irq  out  8  status for IRQ/NMI push: bit5=1, bit4=0
- c_fwd  out  1  carry value P.C will hold after the pending command commits; feeds ALU ci
- pend  out  1  a non-NOP command is in stage 2

Behaviour:
- Interface: reset rst, synchronous, active-high; clock clk. All state updates on posedge clk.
- Stage 1 registers, loaded every edge: op_r <= flag_op, bus_r <= bus_in.
- Stage 2 is combinational: it computes next P from op_r, bus_r and the ALU inputs. P is written at the following edge.
- Latency: a command issued before edge k is visible on p after edge k+1. Throughput is one command per cycle, with no stalls.
- Reset: op_r = FLG_NOP, bus_r = 0, P = RESET_P. Outputs after reset: p = RESET_P|8'h30, p_irq = RESET_P|8'h20, pend = 0. A command in flight at reset is discarded.
- Definitions used below: Zr = (alu_out==0); Nr = alu_out[7].
- Commands and the bits they change (all other bits hold):
  - FLG_NOP: none
  - FLG_NZ: N=Nr, Z=Zr (LDx, TAX, AND/ORA/EOR, INC/DEC)
  - FLG_NZC: N, Z, C=alu_c (CMP/CPX/CPY)
  - FLG_NZCV: N, Z, C=alu_c, V=alu_v (ADC/SBC)
  - FLG_NZS: N, Z, C=shift_c (shifts/rotates)
  - FLG_BIT: Z=Zr (ALU performs AND), N=bus_r[7], V=bus_r[6]
  - FLG_PLP: P = bus_r with bits 5/4 discarded (PLP/RTI)
  - FLG_CLC/SEC/CLI/SEI/CLV/CLD/SED: clear/set the single bit
  - FLG_INT: I=1 (BRK/IRQ/NMI entry)
  - Remaining encodings behave as NOP.
- c_fwd: the next-state C when op_r modifies C, otherwise P.C. This ensures a SEC immediately followed by ADC adds with carry 1.
- D is stored only; it has no arithmetic effect.
- p and p_irq are combinational from the P register. They do not show the pending command.

Decomposition:
- cpu_pkg (shared with the decoder) holds:
  - flag_op_t enum: 4 bits, FLG_NOP=0.
  - Bit-index constants: FLAG_N=7, FLAG_V=6, FLAG_U=5, FLAG_B=4, FLAG_D=3, FLAG_I=2, FLAG_Z=1, FLAG_C=0.
- Single module. The next-P logic is one always_comb shared by the register and c_fwd; no sub-module.

Test Plan:
- Reset: hold rst for 2 cycles -> p=8'h34, p_irq=8'h24, c_fwd=0, pend=0.
- ADC 0x50+0x50: FLG_NZCV with alu_out=A0, alu_c=0, alu_v=1 -> after latency p=8'hF4. CMP: FLG_NZC with alu_out=00, alu_c=1 -> p=8'h37.
- Back-to-back: SEC then FLG_NZCV on consecutive cycles -> c_fwd=1 in the cycle the ADC issues. Then FLG_NZ with alu_out=00 -> Z=1 and C unchanged.
- BIT: bus_in=C0 with alu_out=00 -> N=1, V=1, Z=1, C unchanged. PLP: bus_in=FF -> p=8'hFF; bus_in=00 -> p=8'h30, p_irq=8'h20.
- Shift: FLG_NZS with shift_c=1, alu_out=80 -> N=1, Z=0, C=1. FLG_INT -> I=1. CLI then SEI back-to-back -> I=1 final, with 0 visible for one cycle.
- Reset mid-flight: issue SEC, assert rst on the next edge -> C stays at its RESET_P value and pend=0.
